mem_arbiter: RTL and testbench

- Shares the single multi-cycle, pipelined main memory between three requesters: the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Grants one requester at a time.
- For fills, issues every word address of the block and counts the returning words.
- Routes each returned word to the granted cache and signals completion.
- Sits between the cache controllers and the memory model; its stall outputs feed the pipeline hazard logic.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request/fill signals and main-memory bus signals for mem_arbiter.
// master is the arbiter's view; slave is the cache controllers plus the memory model.
interface mem_arbiter_if #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
);
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              i_fill_valid;
  logic              d_fill_valid;
  logic [WORD_W-1:0] fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              i_done;
  logic              d_done;
  logic              wr_ack;
  logic              i_stall;
  logic              d_stall;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;

  modport master (
    input  i_req, i_addr, d_req, d_addr, wr_req, wr_addr, wr_data,
    input  mem_rdata, mem_data_valid,
    output i_fill_valid, d_fill_valid, fill_word, fill_data,
    output i_done, d_done, wr_ack, i_stall, d_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, wr_req, wr_addr, wr_data,
    output mem_rdata, mem_data_valid,
    input  i_fill_valid, d_fill_valid, fill_word, fill_data,
    input  i_done, d_done, wr_ack, i_stall, d_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the pipelined main memory between I-fill, D-fill and write-through stores.
// Define ARB_RR_EN to alternate contested I/D fill grants instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
  localparam int B      = WORD_W + 1;
  localparam logic [WORD_W-1:0] LAST = WORD_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_ISSUE, FILL_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-B-1:0] base_q, base_d;
  logic [WORD_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic                ret_all_q, ret_all_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                pick_d, pick_i;
  logic                ret_act, ret_last;
  logic                i_done, d_done;

`ifdef ARB_RR_EN
  // last_owner: 0 = I, 1 = D; only contested grants flip it.
  logic last_owner_q, last_owner_d;
  assign pick_d = bus.d_req & (~bus.i_req | ~last_owner_q);
`else
  assign pick_d = bus.d_req;
`endif
  assign pick_i = bus.i_req & ~pick_d;

  // Returns count only while a fill owns the bus and its last word has not yet arrived.
  assign ret_act  = ((state_q == FILL_ISSUE) || (state_q == FILL_WAIT)) &&
                    bus.mem_data_valid && !ret_all_q;
  assign ret_last = ret_act && (ret_cnt_q == LAST);
  assign i_done   = ret_last && (owner_q == OWN_I);
  assign d_done   = ret_last && (owner_q == OWN_D);

  assign bus.i_fill_valid = ret_act && (owner_q == OWN_I);
  assign bus.d_fill_valid = ret_act && (owner_q == OWN_D);
  assign bus.fill_word    = ret_cnt_q;
  assign bus.fill_data    = bus.mem_rdata;
  assign bus.i_done       = i_done;
  assign bus.d_done       = d_done;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.i_stall      = bus.i_req & ~i_done;
  assign bus.d_stall      = (bus.d_req & ~d_done) | (bus.wr_req & ~wr_ack_q);
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    ret_all_d   = ret_all_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    wr_ack_d    = 1'b0;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    if (ret_act) ret_cnt_d = ret_last ? '0 : ret_cnt_q + WORD_W'(1);

    // Memory-side outputs are computed for the state being entered, so they are registered.
    case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          state_d     = WRITE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = bus.wr_addr;
          mem_wdata_d = bus.wr_data;
          wr_ack_d    = 1'b1;
        end else if (pick_d || pick_i) begin
          state_d     = FILL_ISSUE;
          owner_d     = pick_d ? OWN_D : OWN_I;
          base_d      = pick_d ? bus.d_addr[ADDR_W-1:B] : bus.i_addr[ADDR_W-1:B];
          issue_cnt_d = '0;
          ret_all_d   = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = {base_d, {WORD_W{1'b0}}, 1'b0};
`ifdef ARB_RR_EN
          if (bus.d_req && bus.i_req) last_owner_d = pick_d;
`endif
        end
      end
      WRITE: state_d = IDLE;
      FILL_ISSUE: begin
        if (issue_cnt_q == LAST) begin
          issue_cnt_d = '0;
          // A block that already returned in full skips the wait state.
          if (ret_all_q || ret_last) begin
            state_d   = IDLE;
            owner_d   = OWN_NONE;
            ret_all_d = 1'b0;
          end else begin
            state_d = FILL_WAIT;
          end
        end else begin
          issue_cnt_d = issue_cnt_q + WORD_W'(1);
          mem_en_d    = 1'b1;
          mem_addr_d  = {base_q, issue_cnt_d, 1'b0};
          if (ret_last) ret_all_d = 1'b1;
        end
      end
      FILL_WAIT: begin
        if (ret_last) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      ret_all_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
`ifdef ARB_RR_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      ret_all_q   <= ret_all_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
`ifdef ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model (rdata = addr ^ 0x5A5A).
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  logic spur;
  int   n_cmp;
  int   n_err;

  mem_arbiter_if #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a read issued in cycle t returns in cycle t+4; it is reset with the arbiter.
  logic [3:0]  pv;
  logic [15:0] pd0, pd1, pd2, pd3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0; pd3 <= '0;
    end else begin
      pv  <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
      pd0 <= bus.mem_addr ^ 16'h5A5A;
      pd1 <= pd0;
      pd2 <= pd1;
      pd3 <= pd2;
    end
  end
  assign bus.mem_data_valid = pv[3] | spur;
  assign bus.mem_rdata      = spur ? 16'hDEAD : pd3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Call at the check point of the cycle in which the request is sampled (cycle T).
  // Checks T+1..T+13 and drops the owner's request in T+13.
  task automatic fill_seq(input bit is_d, input logic [15:0] base, input int wr_cyc);
    logic exp_v;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 13) begin
        if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      end
      if (c == wr_cyc) begin
        bus.wr_req = 1'b1; bus.wr_addr = 16'h0100; bus.wr_data = 16'hBEEF;
      end
      #4;
      check("mem_en", 32'(bus.mem_en), 32'(c <= 8));
      check("mem_wr", 32'(bus.mem_wr), 32'd0);
      if (c <= 8) check("mem_addr", 32'(bus.mem_addr), 32'(base + 16'(2 * (c - 1))));
      exp_v = (c >= 5) && (c <= 12);
      check(is_d ? "d_fill_valid" : "i_fill_valid",
            32'(is_d ? bus.d_fill_valid : bus.i_fill_valid), 32'(exp_v));
      check(is_d ? "i_fill_valid_other" : "d_fill_valid_other",
            32'(is_d ? bus.i_fill_valid : bus.d_fill_valid), 32'd0);
      if (exp_v) begin
        check("fill_word", 32'(bus.fill_word), 32'(c - 5));
        check("fill_data", 32'(bus.fill_data), 32'((base + 16'(2 * (c - 5))) ^ 16'h5A5A));
      end
      check(is_d ? "d_done" : "i_done", 32'(is_d ? bus.d_done : bus.i_done), 32'(c == 12));
      check("done_other", 32'(is_d ? bus.i_done : bus.d_done), 32'd0);
      if (!is_d) check("i_stall", 32'(bus.i_stall), 32'(c < 12));
      else if (!bus.wr_req) check("d_stall", 32'(bus.d_stall), 32'(c < 12));
      if (bus.wr_req) check("d_stall_wr", 32'(bus.d_stall), 32'd1);
    end
  endtask

  // Write cycle then the following IDLE cycle, in which wr_req is dropped.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic exp_dst);
    @(posedge clk); #5;
    check("wr_mem_en", 32'(bus.mem_en), 32'd1);
    check("wr_mem_wr", 32'(bus.mem_wr), 32'd1);
    check("wr_mem_addr", 32'(bus.mem_addr), 32'(a));
    check("wr_mem_wdata", 32'(bus.mem_wdata), 32'(d));
    check("wr_ack", 32'(bus.wr_ack), 32'd1);
    check("wr_d_stall", 32'(bus.d_stall), 32'(exp_dst));
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    #4;
    check("wr_ack_low", 32'(bus.wr_ack), 32'd0);
    check("wr_mem_en_low", 32'(bus.mem_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; spur = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

    // Reset state
    @(posedge clk); #5;
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_valids", 32'({bus.i_fill_valid, bus.d_fill_valid}), 32'd0);
    check("rst_done_ack", 32'({bus.i_done, bus.d_done, bus.wr_ack}), 32'd0);
    check("rst_fill_word", 32'(bus.fill_word), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; #4;

    // Spurious valid in IDLE
    @(posedge clk); #1; spur = 1'b1; #4;
    check("spur_valids", 32'({bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done}), 32'd0);
    @(posedge clk); #1; spur = 1'b0; #4;
    check("spur_fill_word", 32'(bus.fill_word), 32'd0);
    check("spur_mem_en", 32'(bus.mem_en), 32'd0);

    // Single I miss at 0x1234
    @(posedge clk); #1; bus.i_req = 1'b1; bus.i_addr = 16'h1234; #4;
    check("i_stall_req", 32'(bus.i_stall), 32'd1);
    fill_seq(1'b0, 16'h1230, 0);

    // Simultaneous misses
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 16'h4000; bus.i_req = 1'b1; bus.i_addr = 16'h8000; #4;
    fill_seq(1'b1, 16'h4000, 0);
    fill_seq(1'b0, 16'h8000, 0);

    // Second simultaneous pair
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 16'h4100; bus.i_req = 1'b1; bus.i_addr = 16'h8100; #4;
`ifdef ARB_RR_EN
    fill_seq(1'b0, 16'h8100, 0);
    fill_seq(1'b1, 16'h4100, 0);
`else
    fill_seq(1'b1, 16'h4100, 0);
    fill_seq(1'b0, 16'h8100, 0);
`endif

    // Store arriving during an I fill
    @(posedge clk); #1; bus.i_req = 1'b1; bus.i_addr = 16'h2006; #4;
    fill_seq(1'b0, 16'h2000, 4);
    do_write(16'h0100, 16'hBEEF, 1'b0);

    // Store plus D miss together
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0220; bus.wr_data = 16'h1357;
    bus.d_req = 1'b1; bus.d_addr = 16'h4A16; #4;
    do_write(16'h0220, 16'h1357, 1'b1);
    fill_seq(1'b1, 16'h4A10, 0);

    // Reset after three returned words
    @(posedge clk); #1; bus.i_req = 1'b1; bus.i_addr = 16'h3000; #4;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #5;
    end
    check("pre_rst_fill_word", 32'(bus.fill_word), 32'd2);
    @(posedge clk); #1; rst_n = 1'b0; #4;
    check("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_valid", 32'({bus.i_fill_valid, bus.d_fill_valid}), 32'd0);
    check("mid_rst_done", 32'({bus.i_done, bus.d_done}), 32'd0);
    check("mid_rst_fill_word", 32'(bus.fill_word), 32'd0);
    @(posedge clk); #5;
    check("mid_rst_done2", 32'(bus.i_done), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1; #4;
    fill_seq(1'b0, 16'h3000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
